char_write_ctrl: RTL and testbench

Write scheduler for the character-row text buffers. It accepts character-write and row-clear commands from the host command decoder over a valid/ready handshake. It drives the shared write port (write strobe, column coordinate, character code) of all ROWS char_row instances, with a one-hot row select. Writes are issued only while the VGA timing generator reports blanking, so the active scan never reads a half-updated row.

---
 rtl/char_gfx_pkg.sv | 24 ++
 rtl/char_write_ctrl_if.sv | 35 +++
 rtl/char_write_ctrl_row_decoder.sv | 28 ++
 rtl/char_write_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_char_write_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/char_gfx_pkg.sv
// Shared types and default geometry for the character-row text buffer blocks.
// Consumed by char_write_ctrl (optional clear support via CHAR_WRITE_CTRL_CLEAR_EN).
package char_gfx_pkg;

    localparam int DEF_ROWS        = 30;
    localparam int DEF_COLS        = 80;
    localparam int DEF_CHAR_W_LOG2 = 3;

    typedef logic [5:0] char_t;

    localparam char_t DEF_BLANK_CHAR = 6'b000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_t;

    // Pixel x of a character cell; the shift is done at 10 bits so high bits drop.
    function automatic logic [9:0] cell_xcoor(input logic [9:0] col, input int log2w);
        return col << log2w;
    endfunction

endpackage

// File: rtl/char_write_ctrl_if.sv
// Host command request channel (valid/ready) into char_write_ctrl.
// Master = command decoder, slave = write controller.
interface char_write_ctrl_if
    import char_gfx_pkg::*;
#(
    parameter int ROW_W = $clog2(DEF_ROWS),
    parameter int COL_W = $clog2(DEF_COLS)
);

    logic             req_valid;
    logic             req_ready;
    logic             req_clear;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    char_t            req_char;

    modport master (
        output req_valid,
        output req_clear,
        output req_row,
        output req_col,
        output req_char,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_clear,
        input  req_row,
        input  req_col,
        input  req_char,
        output req_ready
    );

endinterface

// File: rtl/char_write_ctrl_row_decoder.sv
// Row index + strobe to one-hot row write enables; rows beyond ROWS-1 never strobe.
// hit reports whether any row was actually selected.
module row_decoder #(
    parameter int ROWS  = 30,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic [ROW_W-1:0] row,
    input  logic             strobe,
    output logic [ROWS-1:0]  row_we,
    output logic             hit
);

    // One-hot decode with out-of-range suppression
    always_comb begin
        row_we = '0;
        hit    = 1'b0;
        if (strobe && (int'(row) < ROWS)) begin
            hit = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                row_we[r] = (int'(row) == r);
            end
        end else begin
            hit    = 1'b0;
            row_we = '0;
        end
    end

endmodule

// File: rtl/char_write_ctrl.sv
// Blanking-gated write scheduler for the char_row text buffers.
// Define CHAR_WRITE_CTRL_CLEAR_EN to build the whole-row clear (CLEAR state + column counter).
module char_write_ctrl
    import char_gfx_pkg::*;
#(
    parameter int    ROWS        = DEF_ROWS,
    parameter int    COLS        = DEF_COLS,
    parameter int    CHAR_W_LOG2 = DEF_CHAR_W_LOG2,
    parameter char_t BLANK_CHAR  = DEF_BLANK_CHAR
) (
    input  logic             clk,
    input  logic             rst,
    char_write_ctrl_if.slave req,
    input  logic             blank,
    output logic [ROWS-1:0]  row_we,
    output logic [9:0]       xcoor,
    output char_t            char_in,
    output logic             busy
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    ctrl_state_t      state_r;
    logic             req_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    char_t            char_r;
    logic [ROWS-1:0]  row_we_r;
    logic [9:0]       xcoor_r;
    char_t            char_in_r;
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
    logic [COL_W-1:0] cnt_r;
    logic             last_col_s;
`endif

    logic             accept_s;
    logic             issue_s;
    logic             col_ok_s;
    logic             hit_s;
    logic [ROW_W-1:0] wr_row_s;
    logic [COL_W-1:0] wr_col_s;
    char_t            wr_char_s;
    logic [ROWS-1:0]  row_we_s;
    logic [9:0]       xcoor_s;

    assign accept_s  = req.req_valid && req_ready_r;
    assign col_ok_s  = (int'(wr_col_s) < COLS);
    assign xcoor_s   = cell_xcoor(10'(wr_col_s), CHAR_W_LOG2);
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
    assign last_col_s = (int'(wr_col_s) == (COLS - 1));
`endif

    assign req.req_ready = req_ready_r;
    assign row_we        = row_we_r;
    assign xcoor         = xcoor_r;
    assign char_in       = char_in_r;
    assign busy          = busy_r;

    // Select the cell to write this edge; the strobe is taken straight from
    // the accepting edge so a write with blank high lands one cycle later.
    always_comb begin
        issue_s   = 1'b0;
        wr_row_s  = row_r;
        wr_col_s  = col_r;
        wr_char_s = char_r;
        case (state_r)
            IDLE: begin
                wr_row_s = req.req_row;
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
                if (req.req_clear) begin
                    wr_col_s  = '0;
                    wr_char_s = BLANK_CHAR;
                end else begin
                    wr_col_s  = req.req_col;
                    wr_char_s = req.req_char;
                end
`else
                wr_col_s  = req.req_col;
                wr_char_s = req.req_char;
`endif
                issue_s = accept_s && blank;
            end
            WRITE: begin
                issue_s = !done_r && blank;
            end
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
            CLEAR: begin
                wr_col_s  = cnt_r;
                wr_char_s = BLANK_CHAR;
                issue_s   = !done_r && blank;
            end
`endif
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    row_decoder #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_row_decoder (
        .row    (wr_row_s),
        .strobe (issue_s && col_ok_s),
        .row_we (row_we_s),
        .hit    (hit_s)
    );

    // Command FSM and registered write port; done_r marks "last strobe issued"
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            row_r       <= '0;
            col_r       <= '0;
            char_r      <= '0;
            row_we_r    <= '0;
            xcoor_r     <= 10'd0;
            char_in_r   <= '0;
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
            cnt_r       <= '0;
`endif
        end else begin
            row_we_r  <= row_we_s;
            xcoor_r   <= hit_s ? xcoor_s : 10'd0;
            char_in_r <= hit_s ? wr_char_s : 6'd0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        row_r       <= req.req_row;
                        col_r       <= req.req_col;
                        char_r      <= req.req_char;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
                        if (req.req_clear) begin
                            state_r <= CLEAR;
                            cnt_r   <= blank ? COL_W'(1) : COL_W'(0);
                            done_r  <= blank && last_col_s;
                        end else begin
                            state_r <= WRITE;
                            done_r  <= blank;
                        end
`else
                        state_r <= WRITE;
                        done_r  <= blank;
`endif
                    end
                end
                WRITE: begin
                    if (done_r) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end else if (blank) begin
                        done_r <= 1'b1;
                    end
                end
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
                CLEAR: begin
                    if (done_r) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                        cnt_r       <= '0;
                    end else if (blank) begin
                        cnt_r  <= cnt_r + COL_W'(1);
                        done_r <= last_col_s;
                    end
                end
`endif
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_write_ctrl.sv
// Self-checking bench for char_write_ctrl: directed vector table, multi-cycle
// clear/reset sequences, then random traffic against a queue-based reference model.
module tb_char_write_ctrl;
    import char_gfx_pkg::*;

    localparam int ROWS  = 30;
    localparam int COLS  = 80;
    localparam int CW    = 3;
    localparam int ROW_W = 5;
    localparam int COL_W = 7;
`ifdef CHAR_WRITE_CTRL_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        blank;
    logic [29:0] row_we;
    logic [9:0]  xcoor;
    logic [5:0]  char_in;
    logic        busy;

    char_write_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) rif ();

    char_write_ctrl #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CHAR_W_LOG2 (CW),
        .BLANK_CHAR  (6'b000000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (rif),
        .blank   (blank),
        .row_we  (row_we),
        .xcoor   (xcoor),
        .char_in (char_in),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a command is a list of columns still to be written.
    bit          m_busy = 1'b0;
    int          m_q[$];
    int          m_row;
    logic [5:0]  m_char;
    logic [29:0] e_we;
    logic [9:0]  e_x;
    logic [5:0]  e_c;
    logic        e_rdy;
    logic        e_bsy;

    typedef struct {
        logic        r, v, clr;
        logic [4:0]  row;
        logic [6:0]  col;
        logic [5:0]  ch;
        logic        bl;
        logic [29:0] we;
        logic [9:0]  x;
        logic [5:0]  c;
        logic        rdy, bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic clr, logic [4:0] row, logic [6:0] col,
                                logic [5:0] ch, logic bl, logic [29:0] we, logic [9:0] x,
                                logic [5:0] c, logic rdy, logic bsy);
        vec_t t;
        t = '{r, v, clr, row, col, ch, bl, we, x, c, rdy, bsy};
        return t;
    endfunction

    task automatic model_emit();
        int c;
        c = m_q.pop_front();
        if (m_row < ROWS && c < COLS) begin
            e_we = 30'd1 << m_row;
            e_x  = 10'(c * (1 << CW));
            e_c  = m_char;
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic clr, input int row,
                              input int col, input logic [5:0] ch, input logic bl);
        e_we = '0;
        e_x  = '0;
        e_c  = '0;
        if (r) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_row  = row;
                if (CLEAR_EN && clr) begin
                    m_char = 6'b000000;
                    for (int k = 0; k < COLS; k++) m_q.push_back(k);
                end else begin
                    m_char = ch;
                    m_q.push_back(col);
                end
                if (bl) model_emit();
            end
        end else if (m_q.size() == 0) begin
            m_busy = 1'b0;
        end else if (bl) begin
            model_emit();
        end
        e_rdy = !m_busy;
        e_bsy = m_busy;
    endtask

    task automatic step(input logic r, input logic v, input logic clr, input logic [4:0] row,
                        input logic [6:0] col, input logic [5:0] ch, input logic bl);
        rst           = r;
        rif.req_valid = v;
        rif.req_clear = clr;
        rif.req_row   = row;
        rif.req_col   = col;
        rif.req_char  = ch;
        blank         = bl;
        @(posedge clk);
        model_edge(r, v, clr, int'(row), int'(col), ch, bl);
        #1;
    endtask

    task automatic chk(input string name, input logic [29:0] we, input logic [9:0] x,
                       input logic [5:0] c, input logic rdy, input logic bsy);
        checks++;
        if (row_we !== we || xcoor !== x || char_in !== c || rif.req_ready !== rdy || busy !== bsy) begin
            errors++;
            $display("FAIL %s: got we=%h x=%0d ch=%h rdy=%b busy=%b, want we=%h x=%0d ch=%h rdy=%b busy=%b",
                     name, row_we, xcoor, char_in, rif.req_ready, busy, we, x, c, rdy, bsy);
        end
    endtask

    initial begin
        int col_exp;
        int lows;
        int nstep;
        logic bl;
        logic r, v, clr;
        logic [4:0] row;
        logic [6:0] col;

        // Directed per-cycle vectors: inputs before the edge, outputs after it
        tbl.push_back(mk(1, 1, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(1, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0,  3,   5, 6'h2A, 1, 30'd1 << 3, 10'd40,  6'h2A, 0, 1));
        tbl.push_back(mk(0, 1, 0,  7,   1, 6'h15, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0,  3,   5, 6'h2A, 0, 30'd0,      10'd0,   6'h00, 0, 1));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 30'd0,    10'd0,   6'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd1 << 3, 10'd40,  6'h2A, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 31,   5, 6'h2A, 1, 30'd0,      10'd0,   6'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0,  2, 100, 6'h2A, 1, 30'd0,      10'd0,   6'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 29,  79, 6'h3F, 1, 30'd1 << 29, 10'd632, 6'h3F, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
`ifndef CHAR_WRITE_CTRL_CLEAR_EN
        tbl.push_back(mk(0, 1, 1,  4,   2, 6'h11, 1, 30'd1 << 4, 10'd16,  6'h11, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0,   0, 6'h00, 1, 30'd0,      10'd0,   6'h00, 1, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].clr, tbl[i].row, tbl[i].col, tbl[i].ch, tbl[i].bl);
            chk($sformatf("vec%0d", i), tbl[i].we, tbl[i].x, tbl[i].c, tbl[i].rdy, tbl[i].bsy);
        end

`ifdef CHAR_WRITE_CTRL_CLEAR_EN
        // Clear row 0 with a 4-cycle blanking gap at column 40
        step(0, 1, 1, 0, 0, 6'h3F, 1);
        nstep = 1;
        chk("clr_first", 30'd1, 10'd0, 6'h00, 0, 1);
        col_exp = 1;
        lows    = 0;
        while (col_exp < COLS && nstep < 200) begin
            bl = !(col_exp == 40 && lows < 4);
            if (!bl) lows++;
            step(0, 0, 0, 0, 0, 6'h00, bl);
            nstep++;
            if (bl) begin
                chk($sformatf("clr_col%0d", col_exp), 30'd1, 10'(col_exp * 8), 6'h00, 0, 1);
                col_exp++;
            end else begin
                chk("clr_gap", 30'd0, 10'd0, 6'h00, 0, 1);
            end
        end
        checks++;
        if (nstep != COLS + 4 || col_exp != COLS) begin
            errors++;
            $display("FAIL clr_span: got %0d cycles, want %0d", nstep, COLS + 4);
        end
        step(0, 0, 0, 0, 0, 6'h00, 1);
        chk("clr_done", 30'd0, 10'd0, 6'h00, 1, 0);

        // Reset lands on strobe 20 of a clear of row 5
        step(0, 1, 1, 5, 0, 6'h00, 1);
        chk("rc_s0", 30'd1 << 5, 10'd0, 6'h00, 0, 1);
        for (int k = 1; k < 20; k++) begin
            step(0, 0, 0, 0, 0, 6'h00, 1);
            chk($sformatf("rc_s%0d", k), 30'd1 << 5, 10'(k * 8), 6'h00, 0, 1);
        end
`else
        // Reset lands while a write waits for blanking
        step(0, 1, 0, 1, 9, 6'h07, 0);
        chk("rw_acc", 30'd0, 10'd0, 6'h00, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 6'h00, 0);
            chk("rw_wait", 30'd0, 10'd0, 6'h00, 0, 1);
        end
`endif
        step(1, 0, 0, 0, 0, 6'h00, 1);
        chk("rst_abort", 30'd0, 10'd0, 6'h00, 1, 0);
        step(0, 1, 0, 1, 1, 6'h03, 1);
        chk("rst_new", 30'd2, 10'd8, 6'h03, 0, 1);
        step(0, 0, 0, 0, 0, 6'h00, 1);
        chk("rst_idle", 30'd0, 10'd0, 6'h00, 1, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            row = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 29));
            col = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
            bl  = ($urandom_range(0, 3) != 0);
            step(r, v, clr, row, col, 6'($urandom_range(0, 63)), bl);
            chk($sformatf("rand%0d", n), e_we, e_x, e_c, e_rdy, e_bsy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
